response_framer: RTL and testbench

- Sits between the sensor decode stage and the UART transmitter on the reply path.
- Accepts completed sensor responses as {response code, data byte} pairs and buffers them in a small FIFO.
- Sends each response as a two-byte frame (code first, then data) to the UART transmitter, waiting for the transmitter's per-byte completion pulse.
- Aborts a frame and reports it if the transmitter does not complete a byte within a timeout.

---
 rtl/response_framer.sv | 186 ++++++++++++++++++
 tb/tb_response_framer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/response_framer.sv
// rtl/response_framer.sv - response queue and two-byte UART reply framer
//
// response_queue: DEPTH-entry FIFO of {code, data} pairs.
//   clock, reset       : system clock, synchronous active-high reset
//   push, push_data    : offer an entry; accepted when not full or when popping
//   pop                : remove head entry (caller only pops when count != 0)
//   head_data          : entry at the read pointer
//   count              : number of stored entries
//   dropped            : a push was refused this cycle
//
// response_framer: buffers responses and sends each as code byte then data byte.
//   clock, reset                          : system clock, synchronous active-high reset
//   response_valid/code/data              : one-cycle response strobe and payload
//   queue_full, busy                      : queue status and activity indication
//   tx_has_data, tx_data, tx_done         : UART transmitter handshake
//   frame_sent, tx_timeout                : one-cycle frame completion / abort pulses
//   overflow                              : sticky, a response was dropped

module response_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             accept;

  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign accept    = push && ((count < (PW+1)'(DEPTH)) || pop);
  assign dropped   = push && !accept;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

endmodule

module response_framer #(
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       response_valid,
  input  logic [7:0] response_code,
  input  logic [7:0] response_data,
  output logic       queue_full,
  output logic       busy,
  output logic       tx_has_data,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       frame_sent,
  output logic       tx_timeout,
  output logic       overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_CODE,
    WAIT_CODE,
    SEND_DATA,
    WAIT_DATA
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   count;
  logic [15:0]     head_data;
  logic            pop;
  logic            dropped;
  logic [7:0]      hold_data;
  logic [TW-1:0]   timer;
  logic            timer_hit;
  logic            waiting;

  response_queue #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (response_valid),
    .push_data ({response_code, response_data}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count),
    .dropped   (dropped)
  );

  assign waiting     = (state == WAIT_CODE) || (state == WAIT_DATA);
  assign timer_hit   = (timer == TIMER_LAST);
  assign tx_has_data = (state == SEND_CODE) || (state == SEND_DATA);
  assign queue_full  = (count == CW'(DEPTH));
  assign busy        = (state != IDLE) || (count != '0);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = SEND_CODE;
        end
      end
      SEND_CODE: next_state = WAIT_CODE;
      // tx_done takes priority over an expiring timer in the same cycle.
      WAIT_CODE: begin
        if (tx_done)        next_state = SEND_DATA;
        else if (timer_hit) next_state = IDLE;
      end
      SEND_DATA: next_state = WAIT_DATA;
      WAIT_DATA: begin
        if (tx_done || timer_hit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tx_data    <= '0;
      hold_data  <= '0;
      timer      <= '0;
      frame_sent <= 1'b0;
      tx_timeout <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= next_state;
      frame_sent <= (state == WAIT_DATA) && tx_done;
      tx_timeout <= waiting && !tx_done && timer_hit;
      overflow   <= overflow | dropped;

      // tx_data is loaded on the edge into a SEND state, so it is valid for
      // the whole strobe cycle and holds until the next byte.
      if (pop) begin
        tx_data   <= head_data[15:8];
        hold_data <= head_data[7:0];
      end else if ((state == WAIT_CODE) && tx_done) begin
        tx_data <= hold_data;
      end

      if (tx_has_data) begin
        timer <= '0;
      end else if (waiting && !tx_done && !timer_hit) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_response_framer.sv
// tb/tb_response_framer.sv - directed scoreboard bench for response_framer

module tb_response_framer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       response_valid = 1'b0;
  logic [7:0] response_code = '0;
  logic [7:0] response_data = '0;
  logic       queue_full;
  logic       busy;
  logic       tx_has_data;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic       frame_sent;
  logic       tx_timeout;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int w;

  // Expected transmitted bytes in order; bit 8 marks "nothing expected".
  logic [8:0] exp_q [$];

  response_framer #(
    .DEPTH          (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .response_valid (response_valid),
    .response_code  (response_code),
    .response_data  (response_data),
    .queue_full     (queue_full),
    .busy           (busy),
    .tx_has_data    (tx_has_data),
    .tx_data        (tx_data),
    .tx_done        (tx_done),
    .frame_sent     (frame_sent),
    .tx_timeout     (tx_timeout),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one response for one cycle; expected bytes are queued by caller.
  task automatic push(input logic [7:0] code, input logic [7:0] data);
    response_valid = 1'b1;
    response_code  = code;
    response_data  = data;
    tick();
    response_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] code, input logic [7:0] data);
    exp_q.push_back({1'b0, code});
    exp_q.push_back({1'b0, data});
  endtask

  task automatic wait_strobe(input int budget, output int waited);
    waited = 0;
    while (!tx_has_data && waited < budget) begin
      tick();
      waited++;
    end
    check("strobe_seen", {31'b0, tx_has_data}, 32'd1);
  endtask

  // From a strobe cycle S: tx_done is high in cycle S+delay, returns in S+delay+1.
  task automatic tx_ack(input int delay);
    repeat (delay) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Scoreboard consumer: every byte strobe must match the next expected byte.
  always @(negedge clock) begin
    if (tx_has_data) begin
      logic [8:0] exp;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h100;
      check("tx_byte", {23'b0, 1'b0, tx_data}, {23'b0, exp});
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("reset_outputs",
          {24'b0, queue_full, busy, tx_has_data, frame_sent, tx_timeout, overflow, 2'b0},
          32'd0);
    check("reset_tx_data", {24'b0, tx_data}, 32'd0);
    reset = 1'b0;
    tick();

    // Single frame, tx_done 10 cycles after each strobe
    expect_frame(8'h01, 8'h2A);
    push(8'h01, 8'h2A);
    check("busy_after_push", {31'b0, busy}, 32'd1);
    wait_strobe(6, w);
    check("first_latency", w, 32'd1);
    tx_ack(10);
    wait_strobe(2, w);
    check("data_follows_done", w, 32'd0);
    tx_ack(10);
    check("frame_sent_1", {31'b0, frame_sent}, 32'd1);
    check("busy_idle_1", {31'b0, busy}, 32'd0);
    tick();
    check("frame_sent_pulse", {31'b0, frame_sent}, 32'd0);

    // Three pushes accepted back to back, fourth dropped
    expect_frame(8'h11, 8'h12);
    expect_frame(8'h21, 8'h22);
    expect_frame(8'h31, 8'h32);
    push(8'h11, 8'h12);
    push(8'h21, 8'h22);
    push(8'h31, 8'h32);
    check("overflow_before_drop", {31'b0, overflow}, 32'd0);
    push(8'h41, 8'h42);
    check("overflow_set", {31'b0, overflow}, 32'd1);
    check("queue_full", {31'b0, queue_full}, 32'd1);
    tx_ack(2);
    for (int i = 0; i < 5; i++) begin
      wait_strobe(8, w);
      check("b2b_latency", w, (i % 2 == 0) ? 32'd0 : 32'd1);
      tx_ack(3);
    end
    check("frame_sent_3", {31'b0, frame_sent}, 32'd1);
    check("overflow_sticky", {31'b0, overflow}, 32'd1);
    tick();
    check("queue_drained", {30'b0, busy, queue_full}, 32'd0);

    // Timeout in WAIT_CODE drops the data byte; next frame starts
    exp_q.push_back({1'b0, 8'h55});
    expect_frame(8'hB1, 8'hB2);
    push(8'h55, 8'h2A);
    push(8'hB1, 8'hB2);
    check("timeout_code_strobe", {31'b0, tx_has_data}, 32'd1);
    w = 0;
    while (!tx_timeout && w < 40) begin
      tick();
      w++;
    end
    check("timeout_cycles", w, 32'd17);
    tick();
    check("timeout_pulse", {31'b0, tx_timeout}, 32'd0);
    check("next_after_timeout", {31'b0, tx_has_data}, 32'd1);
    tx_ack(4);
    wait_strobe(2, w);
    tx_ack(4);
    check("frame_sent_after_timeout", {31'b0, frame_sent}, 32'd1);

    // tx_done on the WAIT_DATA expiry cycle wins
    expect_frame(8'h61, 8'h62);
    push(8'h61, 8'h62);
    wait_strobe(6, w);
    tx_ack(1);
    wait_strobe(2, w);
    tx_ack(16);
    check("expiry_frame_sent", {31'b0, frame_sent}, 32'd1);
    check("expiry_no_timeout", {31'b0, tx_timeout}, 32'd0);
    tick();
    check("expiry_no_timeout_late", {31'b0, tx_timeout}, 32'd0);

    // Spurious tx_done in IDLE and tx_done on the strobe cycle are ignored
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    check("spurious_idle", {30'b0, busy, tx_has_data}, 32'd0);
    expect_frame(8'h71, 8'h72);
    push(8'h71, 8'h72);
    tick();
    check("coincident_strobe", {31'b0, tx_has_data}, 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("coincident_no_skip", {31'b0, tx_has_data}, 32'd0);
    tx_ack(3);
    wait_strobe(2, w);
    check("coincident_data_latency", w, 32'd0);
    tx_ack(3);
    check("coincident_frame_sent", {31'b0, frame_sent}, 32'd1);

    // Reset during WAIT_DATA with one entry queued
    expect_frame(8'h81, 8'h82);
    push(8'h81, 8'h82);
    wait_strobe(6, w);
    push(8'h91, 8'h92);
    tx_ack(1);
    wait_strobe(2, w);
    tick();
    check("busy_before_reset", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_outputs",
          {24'b0, queue_full, busy, tx_has_data, frame_sent, tx_timeout, overflow, 2'b0},
          32'd0);
    check("midreset_tx_data", {24'b0, tx_data}, 32'd0);
    w = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_has_data || busy) w++;
    end
    check("midreset_quiet", w, 32'd0);
    expect_frame(8'hA5, 8'hA6);
    push(8'hA5, 8'hA6);
    wait_strobe(6, w);
    check("post_reset_latency", w, 32'd1);
    tx_ack(2);
    wait_strobe(2, w);
    tx_ack(2);
    check("post_reset_frame_sent", {31'b0, frame_sent}, 32'd1);

    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
